// File: rtl/attention_pv_accum_if.sv
// P read port, CPU V write port and O read port of the P*V accumulator.
// "master" is the accumulator side; "slave" is the surrounding system.
interface attention_pv_accum_if #(
   parameter int T      = 8,
   parameter int DMAX   = 1024,
   parameter int DATA_W = 32
);
   localparam int TW = $clog2(T);
   localparam int DW = $clog2(DMAX);

   logic              p_re;
   logic [TW-1:0]     p_tq;
   logic [TW-1:0]     p_tk;
   logic [DATA_W-1:0] p_rdata;
   logic              p_rvalid;

   logic              cpu_v_we;
   logic [TW-1:0]     cpu_v_t;
   logic [DW-1:0]     cpu_v_d;
   logic [DATA_W-1:0] cpu_v_wdata;

   logic              o_re;
   logic [TW-1:0]     o_tq;
   logic [DW-1:0]     o_d;
   logic [DATA_W-1:0] o_rdata;
   logic              o_rvalid;

   modport master (
      output p_re, p_tq, p_tk, o_rdata, o_rvalid,
      input  p_rdata, p_rvalid, cpu_v_we, cpu_v_t, cpu_v_d, cpu_v_wdata,
             o_re, o_tq, o_d
   );

   modport slave (
      input  p_re, p_tq, p_tk, o_rdata, o_rvalid,
      output p_rdata, p_rvalid, cpu_v_we, cpu_v_t, cpu_v_d, cpu_v_wdata,
             o_re, o_tq, o_d
   );
endinterface

// File: rtl/attention_pv_accum.sv
// O = P*V accumulator downstream of softmax, with local V/O stores and
// handshaked FP32 multiply / add units (normal numbers, denormals flushed to zero).

module fp_mul_driver #(
   parameter int LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a_bits,
   input  logic [31:0] b_bits,
   output logic        busy,
   output logic        done,
   output logic [31:0] z_bits
);
   logic [31:0] z_pend;
   logic [3:0]  cnt;

   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic               s;
      logic [47:0]        p;
      logic signed [10:0] e;
      logic [23:0]        m;
      logic               g;
      logic               st;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = $signed({3'd0, a[30:23]}) + $signed({3'd0, b[30:23]}) - 11'sd127;
      if (p[47]) begin
         m  = {1'b0, p[46:24]};
         g  = p[23];
         st = |p[22:0];
         e  = e + 11'sd1;
      end else begin
         m  = {1'b0, p[45:23]};
         g  = p[22];
         st = |p[21:0];
      end
      if (g && (st || m[0])) m = m + 24'd1;
      if (m[23]) e = e + 11'sd1;
      if (e <= 11'sd0) return {s, 31'd0};
      if (e >= 11'sd255) return {s, 8'hff, 23'd0};
      return {s, e[7:0], m[22:0]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         z_bits <= 32'd0;
         z_pend <= 32'd0;
         cnt    <= 4'd0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (cnt == 4'd0) begin
               busy   <= 1'b0;
               done   <= 1'b1;
               z_bits <= z_pend;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end else if (start) begin
            z_pend <= fmul(a_bits, b_bits);
            cnt    <= 4'(LAT - 1);
            busy   <= 1'b1;
         end
      end
   end
endmodule

module fp_add_driver #(
   parameter int LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a_bits,
   input  logic [31:0] b_bits,
   output logic        busy,
   output logic        done,
   output logic [31:0] z_bits
);
   logic [31:0] z_pend;
   logic [3:0]  cnt;

   // Three extra LSBs carry guard/round/sticky through align and normalise.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        x;
      logic [31:0]        y;
      logic [26:0]        mx;
      logic [26:0]        my;
      logic [26:0]        sh;
      logic [27:0]        s;
      logic [7:0]         dexp;
      logic signed [10:0] e;
      logic [4:0]         lz;
      logic [23:0]        m;
      if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
      if (a[30:23] == 8'd0) return b;
      if (b[30:23] == 8'd0) return a;
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      mx   = {1'b1, x[22:0], 3'b000};
      my   = {1'b1, y[22:0], 3'b000};
      dexp = x[30:23] - y[30:23];
      if (dexp >= 8'd27) begin
         sh = 27'd1;
      end else begin
         sh = my >> dexp;
         if ((my & ((27'd1 << dexp) - 27'd1)) != 27'd0) sh[0] = 1'b1;
      end
      if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, sh};
      else                s = {1'b0, mx} - {1'b0, sh};
      if (s == 28'd0) return 32'd0;
      e = $signed({3'd0, x[30:23]});
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 11'sd1;
      end else begin
         lz = 5'd0;
         for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
         s = s << lz;
         e = e - $signed({6'd0, lz});
      end
      m = {1'b0, s[25:3]};
      if (s[2] && (s[1] || s[0] || m[0])) m = m + 24'd1;
      if (m[23]) e = e + 11'sd1;
      if (e <= 11'sd0) return {x[31], 31'd0};
      if (e >= 11'sd255) return {x[31], 8'hff, 23'd0};
      return {x[31], e[7:0], m[22:0]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         z_bits <= 32'd0;
         z_pend <= 32'd0;
         cnt    <= 4'd0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (cnt == 4'd0) begin
               busy   <= 1'b0;
               done   <= 1'b1;
               z_bits <= z_pend;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end else if (start) begin
            z_pend <= fadd(a_bits, b_bits);
            cnt    <= 4'(LAT - 1);
            busy   <= 1'b1;
         end
      end
   end
endmodule

// state      | meaning
// IDLE       | waiting for start
// CHECK      | validate D_len
// LD_P_ISSUE | pulse p_re for (r,k)
// LD_P_WAIT  | wait p_rvalid with timeout, capture prow[k]
// ZERO_ACC   | clear accumulator for (r,d)
// MUL        | skip zero P entry or launch multiply
// WAIT_MUL   | wait multiply done
// ADD        | launch acc + product
// WAIT_ADD   | wait add done
// NEXT_K     | advance k or finish the dot product
// WRITE_O    | O[r][d] <= acc
// NEXT_D     | advance d, then row
// DONE       | hold done until start drops
module attention_pv_accum #(
   parameter int T      = 8,
   parameter int DMAX   = 1024,
   parameter int DATA_W = 32,
   parameter int P_TMO  = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          D_len,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   attention_pv_accum_if.master bus
);
   localparam int TW = $clog2(T);
   localparam int DW = $clog2(DMAX);
   localparam int CW = $clog2(P_TMO + 1);
   localparam logic [TW-1:0] T_LAST = TW'(T - 1);

   typedef enum logic [3:0] {
      IDLE, CHECK, LD_P_ISSUE, LD_P_WAIT, ZERO_ACC, MUL, WAIT_MUL,
      ADD, WAIT_ADD, NEXT_K, WRITE_O, NEXT_D, DONE
   } state_t;

   state_t            st;
   logic [TW-1:0]     r;
   logic [TW-1:0]     k;
   logic [DW-1:0]     d;
   logic [15:0]       dlen;
   logic [CW-1:0]     tmo;
   logic [DATA_W-1:0] prow [T];
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] prod;

   logic              mul_start, mul_busy, mul_done;
   logic [31:0]       mul_a, mul_b, mul_z;
   logic              add_start, add_busy, add_done;
   logic [31:0]       add_a, add_b, add_z;

   logic [DATA_W-1:0] v_mem [T*DMAX];
   logic [DATA_W-1:0] o_mem [T*DMAX];

   fp_mul_driver #(.LAT(2)) u_mul (
      .clk(clk), .rst(rst), .start(mul_start), .a_bits(mul_a), .b_bits(mul_b),
      .busy(mul_busy), .done(mul_done), .z_bits(mul_z)
   );

   fp_add_driver #(.LAT(2)) u_add (
      .clk(clk), .rst(rst), .start(add_start), .a_bits(add_a), .b_bits(add_b),
      .busy(add_busy), .done(add_done), .z_bits(add_z)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         bus.p_re  <= 1'b0;
         bus.p_tq  <= '0;
         bus.p_tk  <= '0;
         r         <= '0;
         k         <= '0;
         d         <= '0;
         dlen      <= 16'd0;
         tmo       <= '0;
         acc       <= '0;
         prod      <= '0;
         mul_start <= 1'b0;
         mul_a     <= 32'd0;
         mul_b     <= 32'd0;
         add_start <= 1'b0;
         add_a     <= 32'd0;
         add_b     <= 32'd0;
      end else begin
         bus.p_re  <= 1'b0;
         mul_start <= 1'b0;
         add_start <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  err  <= 1'b0;
                  dlen <= D_len;
                  st   <= CHECK;
               end
            end
            CHECK: begin
               if (dlen == 16'd0 || dlen > 16'(DMAX)) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
                  done <= 1'b1;
                  st   <= DONE;
               end else begin
                  r  <= '0;
                  k  <= '0;
                  st <= LD_P_ISSUE;
               end
            end
            LD_P_ISSUE: begin
               bus.p_re <= 1'b1;
               bus.p_tq <= r;
               bus.p_tk <= k;
               tmo      <= CW'(P_TMO);
               st       <= LD_P_WAIT;
            end
            LD_P_WAIT: begin
               if (bus.p_rvalid) begin
                  prow[k] <= bus.p_rdata;
                  if (k == T_LAST) begin
                     k  <= '0;
                     d  <= '0;
                     st <= ZERO_ACC;
                  end else begin
                     k  <= k + 1'b1;
                     st <= LD_P_ISSUE;
                  end
               end else if (tmo == '0) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
                  done <= 1'b1;
                  st   <= DONE;
               end else begin
                  tmo <= tmo - 1'b1;
               end
            end
            ZERO_ACC: begin
               acc <= '0;
               k   <= '0;
               st  <= MUL;
            end
            MUL: begin
               // A +/-0 weight contributes nothing; skip both FP operations.
               if (prow[k][30:0] == 31'd0) begin
                  st <= NEXT_K;
               end else if (!mul_busy) begin
                  mul_start <= 1'b1;
                  mul_a     <= prow[k];
                  mul_b     <= v_mem[{k, d}];
                  st        <= WAIT_MUL;
               end
            end
            WAIT_MUL: begin
               if (mul_done) begin
                  prod <= mul_z;
                  st   <= ADD;
               end
            end
            ADD: begin
               if (!add_busy) begin
                  add_start <= 1'b1;
                  add_a     <= acc;
                  add_b     <= prod;
                  st        <= WAIT_ADD;
               end
            end
            WAIT_ADD: begin
               if (add_done) begin
                  acc <= add_z;
                  st  <= NEXT_K;
               end
            end
            NEXT_K: begin
               if (k == T_LAST) begin
                  st <= WRITE_O;
               end else begin
                  k  <= k + 1'b1;
                  st <= MUL;
               end
            end
            WRITE_O: st <= NEXT_D;
            NEXT_D: begin
               if ({{(16-DW){1'b0}}, d} == dlen - 16'd1) begin
                  if (r == T_LAST) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                     st   <= DONE;
                  end else begin
                     r  <= r + 1'b1;
                     k  <= '0;
                     st <= LD_P_ISSUE;
                  end
               end else begin
                  d  <= d + 1'b1;
                  st <= ZERO_ACC;
               end
            end
            DONE: begin
               if (!start) begin
                  done <= 1'b0;
                  st   <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   // V is frozen for the whole run so every dot product sees one consistent matrix.
   always_ff @(posedge clk) begin
      if (bus.cpu_v_we && !busy) v_mem[{bus.cpu_v_t, bus.cpu_v_d}] <= bus.cpu_v_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst && st == WRITE_O) o_mem[{r, d}] <= acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.o_rdata  <= '0;
         bus.o_rvalid <= 1'b0;
      end else begin
         bus.o_rvalid <= bus.o_re;
         if (bus.o_re) bus.o_rdata <= o_mem[{bus.o_tq, bus.o_d}];
      end
   end
endmodule

// File: tb/tb_attention_pv_accum.sv
// Randomized bench for attention_pv_accum against a real-arithmetic P*V model.
// Operand values are small dyadic numbers so every FP32 result is exact.
module tb_attention_pv_accum;
   localparam int T      = 8;
   localparam int DMAX   = 1024;
   localparam int DATA_W = 32;
   localparam int P_TMO  = 15;
   localparam int DC     = 16;
   localparam int TW     = $clog2(T);
   localparam int DW     = $clog2(DMAX);

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] D_len;
   logic        busy, done, err;

   attention_pv_accum_if #(.T(T), .DMAX(DMAX), .DATA_W(DATA_W)) bif ();

   attention_pv_accum #(.T(T), .DMAX(DMAX), .DATA_W(DATA_W), .P_TMO(P_TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .D_len(D_len),
      .busy(busy), .done(done), .err(err), .bus(bif)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model
   real         p_r [T][T];
   logic [31:0] p_b [T][T];
   real         v_r [T][DC];
   logic [31:0] o_exp [T][DC];
   bit          o_known [T][DC];

   logic [31:0] p_tab_b [8] = '{32'h00000000, 32'h80000000, 32'h3e000000, 32'h3e800000,
                                32'h3f000000, 32'h3f800000, 32'hbf000000, 32'h3fc00000};
   real         p_tab_r [8] = '{0.0, -0.0, 0.125, 0.25, 0.5, 1.0, -0.5, 1.5};

   function automatic logic [31:0] r2f(input real x);
      real    a;
      int     e;
      longint f;
      logic   s;
      if (x == 0.0) return 32'd0;
      s = (x < 0.0);
      a = s ? -x : x;
      e = 127;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      f = longint'((a - 1.0) * 8388608.0);
      return {s, 8'(e), 23'(f)};
   endfunction

   task automatic set_p(input int r, input int k, input int idx);
      p_b[r][k] = p_tab_b[idx];
      p_r[r][k] = p_tab_r[idx];
   endtask

   task automatic model_run(input int dl);
      real s;
      for (int r = 0; r < T; r++)
         for (int d = 0; d < dl; d++) begin
            s = 0.0;
            for (int k = 0; k < T; k++) s += p_r[r][k] * v_r[k][d];
            o_exp[r][d]   = r2f(s);
            o_known[r][d] = 1'b1;
         end
   endtask

   function automatic int nz_count(input int r);
      int n;
      n = 0;
      for (int k = 0; k < T; k++) if (p_r[r][k] != 0.0) n++;
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // P memory responder: answers each p_re after 1..4 cycles unless held off.
   bit p_hold = 1'b0;
   int p_cnt  = 0;
   initial begin
      bif.p_rvalid = 1'b0;
      bif.p_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bif.p_re === 1'b1) begin
            int dly;
            int tq;
            int tk;
            p_cnt++;
            if (!p_hold) begin
               dly = $urandom_range(1, 4);
               tq  = int'(bif.p_tq);
               tk  = int'(bif.p_tk);
               repeat (dly) @(posedge clk);
               #1;
               bif.p_rvalid = 1'b1;
               bif.p_rdata  = p_b[tq][tk];
               @(posedge clk);
               #1;
               bif.p_rvalid = 1'b0;
            end
         end
      end
   end

   int mul_cnt  = 0;
   int mul_row0 = 0;
   always @(posedge clk) begin
      if (dut.mul_start === 1'b1) begin
         mul_cnt++;
         if (bif.p_tq == '0) mul_row0++;
      end
   end

   task automatic cpu_wr(input int t, input int d, input logic [31:0] w);
      bif.cpu_v_we    = 1'b1;
      bif.cpu_v_t     = TW'(t);
      bif.cpu_v_d     = DW'(d);
      bif.cpu_v_wdata = w;
      tick();
      bif.cpu_v_we    = 1'b0;
   endtask

   task automatic set_v(input int k, input int d, input real x);
      v_r[k][d] = x;
      cpu_wr(k, d, r2f(x));
   endtask

   task automatic rand_v();
      for (int k = 0; k < T; k++)
         for (int d = 0; d < DC; d++)
            set_v(k, d, real'(int'($urandom_range(0, 64)) - 32) / 2.0);
   endtask

   task automatic read_o(input int tq, input int d, output logic [31:0] data, output logic vld);
      bif.o_re = 1'b1;
      bif.o_tq = TW'(tq);
      bif.o_d  = DW'(d);
      tick();
      vld      = bif.o_rvalid;
      data     = bif.o_rdata;
      bif.o_re = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] data;
      logic        vld;
      for (int r = 0; r < T; r++)
         for (int d = 0; d < DC; d++)
            if (o_known[r][d]) begin
               read_o(r, d, data, vld);
               chk($sformatf("%s_vld[%0d][%0d]", tag, r, d), {31'd0, vld}, 32'd1);
               chk($sformatf("%s_o[%0d][%0d]", tag, r, d), data, o_exp[r][d]);
            end
   endtask

   task automatic do_run(input int dl, output int cyc);
      D_len    = 16'(dl);
      mul_cnt  = 0;
      mul_row0 = 0;
      p_cnt    = 0;
      start    = 1'b1;
      cyc      = 0;
      do begin
         tick();
         cyc++;
      end while (!done && cyc < 20000);
      chk($sformatf("run_done_dl%0d", dl), {31'd0, done}, 32'd1);
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      start = 1'b0;
      tick();
      chk("done_drop", {31'd0, done}, 32'd0);
      tick();
   endtask

   initial begin
      int          cyc;
      int          w;
      logic [31:0] data;
      logic        vld;

      rst   = 1'b1;
      start = 1'b0;
      D_len = 16'd0;
      bif.cpu_v_we    = 1'b0;
      bif.cpu_v_t     = '0;
      bif.cpu_v_d     = '0;
      bif.cpu_v_wdata = '0;
      bif.o_re = 1'b0;
      bif.o_tq = '0;
      bif.o_d  = '0;
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_p_re", {31'd0, bif.p_re}, 32'd0);
      chk("rst_p_addr", {26'd0, bif.p_tq, bif.p_tk}, 32'd0);
      chk("rst_o_rdata", bif.o_rdata, 32'd0);
      chk("rst_o_rvalid", {31'd0, bif.o_rvalid}, 32'd0);
      rst = 1'b0;
      tick();

      // identity P, V[k][d]=k+d
      for (int r = 0; r < T; r++)
         for (int k = 0; k < T; k++) set_p(r, k, (r == k) ? 5 : 0);
      for (int k = 0; k < T; k++)
         for (int d = 0; d < DC; d++) set_v(k, d, real'(k + d));
      do_run(4, cyc);
      model_run(4);
      chk("t1_err", {31'd0, err}, 32'd0);
      chk("t1_p_reads", p_cnt, T * T);
      chk("t1_mul_starts", mul_cnt, T * 4);
      read_o(3, 2, data, vld);
      chk("t1_o32", data, 32'h40a00000);
      check_all("t1");

      // uniform 0.125 row against V[k][0]=k
      for (int r = 0; r < T; r++)
         for (int k = 0; k < T; k++) set_p(r, k, 2);
      do_run(1, cyc);
      model_run(1);
      for (int r = 0; r < T; r++) begin
         read_o(r, 0, data, vld);
         chk($sformatf("t2_o[%0d]", r), data, 32'h40600000);
      end
      chk("t2_mul_starts", mul_cnt, T * T);

      // causal P with random weights; V write and O read while busy
      for (int r = 0; r < T; r++)
         for (int k = 0; k < T; k++)
            set_p(r, k, (k > r) ? 0 : ((r == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 7))));
      rand_v();
      fork
         do_run(3, cyc);
         begin
            repeat (20) tick();
            chk("t3_busy_mid", {31'd0, busy}, 32'd1);
            cpu_wr(0, 0, 32'h41200000);
            read_o(4, 3, data, vld);
            chk("t3_o_rd_vld", {31'd0, vld}, 32'd1);
            chk("t3_o_rd", data, o_exp[4][3]);
         end
      join
      model_run(3);
      chk("t3_row0_muls", mul_row0, 3);
      w = 0;
      for (int r = 0; r < T; r++) w += nz_count(r) * 3;
      chk("t3_mul_starts", mul_cnt, w);
      check_all("t3");

      // illegal head dimensions
      do_run(0, cyc);
      chk("t4a_err", {31'd0, err}, 32'd1);
      chk("t4a_lat", {31'd0, cyc <= 3}, 32'd1);
      chk("t4a_p_re", p_cnt, 0);
      do_run(DMAX + 1, cyc);
      chk("t4b_err", {31'd0, err}, 32'd1);
      chk("t4b_lat", {31'd0, cyc <= 3}, 32'd1);
      chk("t4b_p_re", p_cnt, 0);
      chk("t4_mul_starts", mul_cnt, 0);
      check_all("t4");

      // P timeout, then recovery with fresh data
      p_hold = 1'b1;
      do_run(2, cyc);
      chk("t5_err", {31'd0, err}, 32'd1);
      chk("t5_p_re", p_cnt, 1);
      chk("t5_lat", {31'd0, cyc >= P_TMO + 2 && cyc <= P_TMO + 6}, 32'd1);
      p_hold = 1'b0;
      for (int r = 0; r < T; r++)
         for (int k = 0; k < T; k++) set_p(r, k, int'($urandom_range(0, 7)));
      rand_v();
      do_run(5, cyc);
      model_run(5);
      chk("t5_err_clr", {31'd0, err}, 32'd0);
      check_all("t5");

      // reset during an add
      for (int r = 0; r < T; r++)
         for (int k = 0; k < T; k++) set_p(r, k, int'($urandom_range(2, 7)));
      rand_v();
      D_len = 16'd4;
      start = 1'b1;
      w = 0;
      while (dut.add_start !== 1'b1 && w < 2000) begin
         tick();
         w++;
      end
      chk("t6_add_seen", {31'd0, w < 2000}, 32'd1);
      rst = 1'b1;
      tick();
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_done", {31'd0, done}, 32'd0);
      chk("t6_p_re", {31'd0, bif.p_re}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      repeat (10) tick();
      check_all("t6");

      do_run(2, cyc);
      model_run(2);
      chk("t7_err", {31'd0, err}, 32'd0);
      check_all("t7");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
